// File: rtl/eink_panel_timing.sv
// eink_panel_timing: EPD source/gate strobe generator; define EINK_ABORT_EN to add the abort input
module eink_panel_timing #(
  parameter int H_ACTIVE = 200,
  parameter int H_TOTAL  = 206,
  parameter int V_ACTIVE = 600,
  parameter int V_TOTAL  = 614,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 17,
  parameter int PHASE_W  = 7,
  parameter int CL_HALF  = 2,
  parameter int CKV_LOW  = 151,
  parameter int SPH_LEN  = 130,
  parameter int OE_GATE  = 606,
  parameter int SPV_GATE = 607
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PHASE_W-1:0] phase_count,
  input  logic [DATA_W-1:0]  pixel_in,
`ifdef EINK_ABORT_EN
  input  logic               abort,
`endif
  output logic               ready,
  output logic               done,
  output logic [PHASE_W-1:0] phase,
  output logic [ADDR_W-1:0]  address,
  output logic               gmode,
  output logic               spv,
  output logic               ckv,
  output logic               cl,
  output logic               le,
  output logic               oe,
  output logic               sph,
  output logic [DATA_W-1:0]  data
);
  localparam int S_W = $clog2(H_TOTAL);
  localparam int G_W = $clog2(V_TOTAL);
  localparam int C_W = $clog2(CL_HALF + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [C_W-1:0] hc_q, hc_d;
  logic [S_W-1:0] s_q, s_d, s_nxt;
  logic [G_W-1:0] g_q, g_d, g_nxt;
  logic [PHASE_W-1:0] phase_q, phase_d, count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic ready_q, ready_d, done_q, done_d, cl_q, cl_d;
  logic gmode_q, gmode_d, spv_q, spv_d, ckv_q, ckv_d, le_q, le_d, oe_q, oe_d, sph_q, sph_d;
  logic half, tick, s_wrap, g_wrap, frame_end, last, act_now, act_nxt, abort_req;
`ifdef EINK_ABORT_EN
  logic abort_q, abort_d;
  assign abort_req = abort_q | abort;
  // remember an abort seen during RUN until the current frame ends
  always_comb abort_d = state_q == RUN && state_d == RUN && abort_req;
  // abort request register
  always_ff @(posedge clk) abort_q <= rst ? 1'b0 : abort_d;
`else
  assign abort_req = 1'b0;
`endif
  assign half      = state_q == RUN && hc_q == C_W'(CL_HALF - 1);
  assign tick      = half && cl_q;
  assign s_wrap    = s_q == S_W'(H_TOTAL - 1);
  assign g_wrap    = g_q == G_W'(V_TOTAL - 1);
  assign s_nxt     = s_wrap ? '0 : s_q + S_W'(1);
  assign g_nxt     = s_wrap ? (g_wrap ? '0 : g_q + G_W'(1)) : g_q;
  assign frame_end = s_wrap && g_wrap;
  assign last      = frame_end && (phase_q == count_q - PHASE_W'(1) || abort_req);
  assign act_now   = s_q < S_W'(H_ACTIVE) && g_q < G_W'(V_ACTIVE);
  assign act_nxt   = s_nxt < S_W'(H_ACTIVE) && g_nxt < G_W'(V_ACTIVE);
  // next-state: accept start in IDLE, divide clk into cl, advance counters and decode strobes on each tick
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    s_d     = s_q;
    g_d     = g_q;
    phase_d = phase_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    cl_d    = cl_q;
    gmode_d = gmode_q;
    spv_d   = spv_q;
    ckv_d   = ckv_q;
    le_d    = le_q;
    oe_d    = oe_q;
    sph_d   = sph_q;
    if (state_q == IDLE) begin
      if (start && |phase_count) begin
        state_d = RUN;
        ready_d = 1'b0;
        count_d = phase_count;
        hc_d    = C_W'(CL_HALF - 1);
      end
    end else if (tick && last) begin
      state_d = IDLE;
      ready_d = 1'b1;
      done_d  = 1'b1;
      hc_d    = '0;
      cl_d    = 1'b0;
      s_d     = '0;
      g_d     = '0;
      phase_d = '0;
      addr_d  = '0;
      data_d  = '0;
      gmode_d = 1'b0;
      spv_d   = 1'b1;
      ckv_d   = 1'b0;
      le_d    = 1'b0;
      oe_d    = 1'b0;
      sph_d   = 1'b1;
    end else begin
      hc_d = half ? '0 : hc_q + C_W'(1);
      cl_d = cl_q ^ half;
      if (tick) begin
        s_d     = s_nxt;
        g_d     = g_nxt;
        phase_d = phase_q + PHASE_W'(frame_end);
        addr_d  = (s_nxt == '0 && g_nxt == '0) ? '0 : act_nxt ? addr_q + ADDR_W'(1) : addr_q;
        data_d  = act_now ? pixel_in : '0;
        gmode_d = 1'b1;
        ckv_d   = !(s_nxt >= S_W'(CKV_LOW) && s_nxt < S_W'(H_TOTAL - 2));
        sph_d   = !(s_nxt < S_W'(SPH_LEN) && g_nxt < G_W'(V_ACTIVE));
        le_d    = s_nxt == S_W'(H_ACTIVE + 2);
        oe_d    = g_nxt != G_W'(OE_GATE);
        spv_d   = g_nxt != G_W'(SPV_GATE);
      end
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hc_q    <= '0;
      s_q     <= '0;
      g_q     <= '0;
      phase_q <= '0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      cl_q    <= 1'b0;
      gmode_q <= 1'b0;
      spv_q   <= 1'b1;
      ckv_q   <= 1'b0;
      le_q    <= 1'b0;
      oe_q    <= 1'b0;
      sph_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      s_q     <= s_d;
      g_q     <= g_d;
      phase_q <= phase_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      cl_q    <= cl_d;
      gmode_q <= gmode_d;
      spv_q   <= spv_d;
      ckv_q   <= ckv_d;
      le_q    <= le_d;
      oe_q    <= oe_d;
      sph_q   <= sph_d;
    end
  end
  assign ready   = ready_q;
  assign done    = done_q;
  assign phase   = phase_q;
  assign address = addr_q;
  assign data    = data_q;
  assign cl      = cl_q;
  assign gmode   = gmode_q;
  assign spv     = spv_q;
  assign ckv     = ckv_q;
  assign le      = le_q;
  assign oe      = oe_q;
  assign sph     = sph_q;
endmodule

// File: tb/tb_eink_panel_timing.sv
// tb_eink_panel_timing: directed checks of the small-geometry panel timing
module tb_eink_panel_timing;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [6:0] phase_count = '0;
  logic [15:0] pixel_in;
  logic ready, done, gmode, spv, ckv, cl, le, oe, sph;
  logic [6:0] phase;
  logic [7:0] address;
  logic [15:0] data;
  int checks = 0;
  int failures = 0;
`ifdef EINK_ABORT_EN
  logic abort = 1'b0;
`endif
  eink_panel_timing #(
    .H_ACTIVE(4), .H_TOTAL(8), .V_ACTIVE(3), .V_TOTAL(6), .DATA_W(16), .ADDR_W(8),
    .PHASE_W(7), .CL_HALF(1), .CKV_LOW(5), .SPH_LEN(2), .OE_GATE(4), .SPV_GATE(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .phase_count(phase_count), .pixel_in(pixel_in),
`ifdef EINK_ABORT_EN
    .abort(abort),
`endif
    .ready(ready), .done(done), .phase(phase), .address(address), .gmode(gmode),
    .spv(spv), .ckv(ckv), .cl(cl), .le(le), .oe(oe), .sph(sph), .data(data)
  );
  assign pixel_in = {8'd0, address};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_phase"}, 32'(phase), 0);
    chk({tag, "_addr"}, 32'(address), 0);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_cl"}, 32'(cl), 0);
    chk({tag, "_gmode"}, 32'(gmode), 0);
    chk({tag, "_spv"}, 32'(spv), 1);
    chk({tag, "_ckv"}, 32'(ckv), 0);
    chk({tag, "_le"}, 32'(le), 0);
    chk({tag, "_oe"}, 32'(oe), 0);
    chk({tag, "_sph"}, 32'(sph), 1);
  endtask
  initial begin
    int m, n, s, g, q, sp, gp, ea, ed;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    start = 1'b1;
    phase_count = 7'd0;
    @(negedge clk);
    start = 1'b0;
    chk("pc0_ready", 32'(ready), 1);
    chk("pc0_cl", 32'(cl), 0);
    @(negedge clk);
    chk("pc0_ready2", 32'(ready), 1);
    chk("pc0_cl2", 32'(cl), 0);
    start = 1'b1;
    phase_count = 7'd2;
    @(negedge clk);
    start = 1'b0;
    m = 0;
    while (ready === 1'b0 && m < 400) begin
      n = m / 2;
      q = n % 48;
      s = q % 8;
      g = q / 8;
      sp = ((n + 47) % 48) % 8;
      gp = ((n + 47) % 48) / 8;
      ea = n == 0 ? 0 : g < 3 ? (s < 4 ? g * 4 + s : g * 4 + 3) : 11;
      ed = (n == 0 || !(sp < 4 && gp < 3)) ? 0 : gp * 4 + sp;
      chk("run_cl", 32'(cl), m % 2);
      chk("run_done", 32'(done), 0);
      chk("run_phase", 32'(phase), n / 48);
      chk("run_addr", 32'(address), ea);
      chk("run_data", 32'(data), ed);
      chk("run_gmode", 32'(gmode), n == 0 ? 0 : 1);
      chk("run_le", 32'(le), (n != 0 && s == 6) ? 1 : 0);
      chk("run_ckv", 32'(ckv), (n == 0 || s == 5) ? 0 : 1);
      chk("run_spv", 32'(spv), (n != 0 && g == 5) ? 0 : 1);
      chk("run_oe", 32'(oe), (n == 0 || g == 4) ? 0 : 1);
      chk("run_sph", 32'(sph), (n != 0 && s < 2 && g < 3) ? 0 : 1);
      start = m == 50;
      phase_count = m == 50 ? 7'd1 : 7'd2;
      @(negedge clk);
      m++;
    end
    chk("run_len", 32'(m), 192);
    chk("end_done", 32'(done), 1);
    chk("end_ready", 32'(ready), 1);
    chk("end_phase", 32'(phase), 0);
    @(negedge clk);
    chk("end_done_pulse", 32'(done), 0);
    chk("end_cl_idle", 32'(cl), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_running", 32'(ready), 0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("midrst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_nodone", 32'(done), 0);
      chk("midrst_ready", 32'(ready), 1);
    end
`ifdef EINK_ABORT_EN
    start = 1'b1;
    phase_count = 7'd5;
    @(negedge clk);
    start = 1'b0;
    m = 0;
    while (ready === 1'b0 && m < 2000) begin
      abort = phase == 7'd1 && m < 120;
      chk("ab_done", 32'(done), 0);
      @(negedge clk);
      m++;
    end
    abort = 1'b0;
    chk("ab_len", 32'(m), 192);
    chk("ab_done_end", 32'(done), 1);
    chk("ab_phase", 32'(phase), 0);
    @(negedge clk);
    chk("ab_done_pulse", 32'(done), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eink_panel_timing.md
# eink_panel_timing

Parametrised e-ink panel timing generator that drives the source-driver (sph, le, cl, data) and gate-driver (spv, ckv, oe, gmode) strobes of an active-matrix EPD. It runs `phase_count` consecutive frames per update and fetches DATA_W-bit pixel words from the framebuffer/waveform path via `address`/`pixel_in`. Panel geometry and strobe positions are parameters, so one block covers several panel sizes. The block sits between the waveform lookup and the panel pins.

## Interface
- H_ACTIVE, 200: cl periods per line that carry pixel data.
- H_TOTAL, 206: cl periods per line including blanking (> H_ACTIVE+3).
- V_ACTIVE, 600: gate lines carrying data.
- V_TOTAL, 614: gate lines per frame including blanking.
- DATA_W, 8: source data bus width (8 or 16).
- ADDR_W, 17: pixel-word address width (≥ clog2(H_ACTIVE·V_ACTIVE)).
- PHASE_W, 7: width of phase counter and `phase_count`.
- CL_HALF, 2: clk cycles per cl half-period (≥1).
- CKV_LOW, 151: source count at which ckv drops.
- SPH_LEN, 130: source counts sph is held low at line start.
- OE_GATE, 606 / SPV_GATE, 607: gate count at which oe / spv pulse low.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request an update; sampled only while ready=1.
- phase_count  in  PHASE_W  frames per update; captured on start.
- pixel_in  in  DATA_W  pixel word for `address`.
- ready  out  1  idle, start accepted.
- done  out  1  one-clk pulse at end of update.
- phase  out  PHASE_W  current frame index.
- address  out  ADDR_W  pixel-word address.
- gmode, spv, ckv, cl, le, oe, sph  out  1  panel strobes.
- data  out  DATA_W  source data bus.

## Operation
- Reset values: ready=1, done=0, phase=0, address=0, gmode=0, spv=1, ckv=0, cl=0, le=0, oe=0, sph=1, data=0; FSM=IDLE; s=g=0.
- FSM IDLE→RUN on start=1 && phase_count≠0; start with phase_count=0 is ignored (ready stays 1). RUN→IDLE after the last line of frame phase_count−1.
- RUN: cl toggles every CL_HALF clk, starting 0→1. "Tick" = clk on which cl goes 1→0. On each tick source counter s advances 0..H_TOTAL−1, wrapping increments gate counter g 0..V_TOTAL−1; g wrapping increments phase.
- Strobe decode (registered on tick, from updated s,g): ckv=0 iff CKV_LOW ≤ s < H_TOTAL−2, else 1; sph=0 iff s < SPH_LEN && g < V_ACTIVE; le=1 iff s==H_ACTIVE+2; oe=0 iff g==OE_GATE, else 1; spv=0 iff g==SPV_GATE, else 1; gmode=1.
- address: 0 at frame start; +1 on each tick with s<H_ACTIVE && g<V_ACTIVE; last value per frame H_ACTIVE·V_ACTIVE−1, then returns to 0 at next frame start. Arithmetic is modulo 2^ADDR_W.
- data ← pixel_in on each tick in active region, else 0.
- IDLE: cl=0, strobes at reset values, counters held 0.

## Timing
- ready falls one clk after accepted start; first cl rising edge the following clk.
- Update duration, ready falling to ready rising: phase_count·H_TOTAL·V_TOTAL·2·CL_HALF clk.
- done=1 on the same clk ready returns to 1; phase returns to 0 there.
- pixel_in must be valid within 2·CL_HALF−1 clk of an address change; data lags address by one cl period.
- All strobes change only on ticks (cl falling), stable across the cl high phase.
- rst mid-update: every output at reset values on the next clk, no done pulse.
- start asserted during RUN: ignored.

## Configuration
- EINK_ABORT_EN: adds input `abort` (1 bit). With it, abort=1 in RUN latches a request; the block finishes the current frame, then goes IDLE with done=1 and phase=0 even if phase < phase_count−1. Without it, no port; every update runs all phase_count frames.

## Test plan
- Reset: rst=1 for 3 clk → ready=1, spv=1, sph=1, oe=0, cl=0, address=0, data=0.
- Small geometry (H_ACTIVE=4, H_TOTAL=8, V_ACTIVE=3, V_TOTAL=6, CL_HALF=1, OE_GATE=4, SPV_GATE=5, CKV_LOW=5, SPH_LEN=2), phase_count=2, start pulse → ready low exactly 192 clk, one done pulse, phase goes 0→1.
- Same config: address sequence per frame 0..11 then 0; le high only at s=6; ckv low only at s=5; spv low on line 5, oe low on line 4.
- pixel_in = address[DATA_W−1:0], DATA_W=16 → data equals the address of the previous cl period for all 12 active pixels, 0 in blanking.
- start with phase_count=0 → ready stays 1, cl stays 0; rst at mid-frame → outputs reset next clk, no done.
- With EINK_ABORT_EN, phase_count=5, abort in frame 1 → ready rises at end of frame 1 (2 frames elapsed), done pulse once.
